// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three sides of the data-memory arbiter into one interface:
//   CPU side   : run, cpu_req, cpu_wr, cpu_addr, cpu_wdata -> cpu_rdata, enable
//   Peripheral : per_req, per_addr -> per_gnt, per_rdata, per_rvalid
//   Memory     : mem_addr, mem_wr, mem_wdata -> mem_rdata (1-cycle read latency)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (CPU datapath, peripheral and memory macro)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
) ();
    logic          run;
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          enable;

    logic          per_req;
    logic [AW-1:0] per_addr;
    logic          per_gnt;
    logic [DW-1:0] per_rdata;
    logic          per_rvalid;

    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  run, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  per_req, per_addr,
        input  mem_rdata,
        output cpu_rdata, enable,
        output per_gnt, per_rdata, per_rvalid,
        output mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output run, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output per_req, per_addr,
        output mem_rdata,
        input  cpu_rdata, enable,
        input  per_gnt, per_rdata, per_rvalid,
        input  mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port synchronous data memory (1-cycle read latency) between
// the CPU load/store path and a read-only peripheral port, and produces the
// CPU advance/commit enable.
//   - CPU store: committed in the cycle it is granted.
//   - CPU load : two stall cycles (IDLE grant, CPU_RD), commits in CPU_HOLD.
//   - Conflicts in IDLE are resolved round-robin; the CPU wins the first one.
//   - Peripheral reads return per_rvalid/per_rdata one cycle after per_gnt.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   bus    - dmem_arbiter_if.slave (CPU, peripheral and memory signals)
//   stall_cnt, conflict_cnt - only when DMEM_STALL_COUNT_EN is defined
// Build option:
//   DMEM_STALL_COUNT_EN - adds stall_cnt (cycles with run=1 and enable=0)
//                         and conflict_cnt (IDLE cycles with both contenders).
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus
`ifdef DMEM_STALL_COUNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [15:0]      conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CPU_RD   = 2'd1,
        S_CPU_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_cpu;      // 1: CPU won the last grant, 0: peripheral
    logic          w_last_cpu_nxt;

    logic          w_cpu_cont;
    logic          w_cpu_gnt;
    logic          w_per_gnt;
    logic          w_enable;
    logic          w_store;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_per_rvalid_p1;
    logic [DW-1:0] r_per_rdata_p1;
    logic [DW-1:0] r_cpu_rdata_p1;

    // Next state, grants and enable. Everything is forced idle while reset is
    // high so the combinational outputs drop asynchronously with the registers.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_cpu_nxt = r_last_cpu;
        w_cpu_cont     = 1'b0;
        w_cpu_gnt      = 1'b0;
        w_per_gnt      = 1'b0;
        w_enable       = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    w_cpu_cont = bus.cpu_req & bus.run;
                    if (w_cpu_cont && bus.per_req) begin
                        w_cpu_gnt = ~r_last_cpu;
                        w_per_gnt = r_last_cpu;
                    end else begin
                        w_cpu_gnt = w_cpu_cont;
                        w_per_gnt = bus.per_req;
                    end
                    if (w_cpu_gnt) begin
                        if (bus.cpu_wr) begin
                            w_enable = 1'b1;
                        end else begin
                            w_state_nxt = S_CPU_RD;
                        end
                    end else if (!w_cpu_cont) begin
                        w_enable = bus.run;
                    end
                end
                S_CPU_RD: begin
                    // Memory port is free while the load data comes back.
                    w_per_gnt   = bus.per_req;
                    w_state_nxt = S_CPU_HOLD;
                end
                S_CPU_HOLD: begin
                    // The still-asserted cpu_req belongs to this load; ignore it.
                    // Hold here while run is low so the loaded word is not lost.
                    w_per_gnt = bus.per_req;
                    w_enable  = bus.run;
                    if (bus.run) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
            if (w_cpu_gnt) begin
                w_last_cpu_nxt = 1'b1;
            end else if (w_per_gnt) begin
                w_last_cpu_nxt = 1'b0;
            end
        end
    end

    assign w_store     = w_cpu_gnt & bus.cpu_wr;
    assign w_mem_addr  = w_cpu_gnt ? bus.cpu_addr :
                         (w_per_gnt ? bus.per_addr : r_mem_addr);
    assign w_mem_wdata = w_store ? bus.cpu_wdata : r_mem_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_cpu <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_cpu <= w_last_cpu_nxt;
        end
    end

    // p0 -> p1: address phase to data phase of the memory read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_per_rvalid_p1 <= 1'b0;
            r_per_rdata_p1  <= '0;
            r_cpu_rdata_p1  <= '0;
        end else begin
            r_mem_addr      <= w_mem_addr;
            r_mem_wdata     <= w_mem_wdata;
            r_per_rvalid_p1 <= w_per_gnt;
            if (r_per_rvalid_p1) begin
                r_per_rdata_p1 <= bus.mem_rdata;
            end
            if (r_state == S_CPU_RD) begin
                r_cpu_rdata_p1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.enable     = w_enable;
    assign bus.per_gnt    = w_per_gnt;
    assign bus.mem_wr     = w_store;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.cpu_rdata  = r_cpu_rdata_p1;
    assign bus.per_rvalid = r_per_rvalid_p1;
    // The returning word is forwarded in its valid cycle and held afterwards.
    assign bus.per_rdata  = r_per_rvalid_p1 ? bus.mem_rdata : r_per_rdata_p1;

`ifdef DMEM_STALL_COUNT_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (bus.run && !w_enable) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_cpu_cont && bus.per_req) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios plus a randomized run against a transaction-level model
// of the arbiter. Includes a behavioural 1-cycle-latency memory macro.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mem [0:1023];

    dmem_arbiter_if #(.AW(10), .DW(32)) bus ();

`ifdef DMEM_STALL_COUNT_EN
    logic [31:0] stall_cnt;
    logic [15:0] conflict_cnt;
`endif

    dmem_arbiter #(.AW(10), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef DMEM_STALL_COUNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory, read-before-write, 1-cycle latency.
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic set_inputs(input bit r, input bit cr, input bit cw, input logic [9:0] ca,
                              input logic [31:0] cd, input bit pr, input logic [9:0] pa);
        bus.run = r; bus.cpu_req = cr; bus.cpu_wr = cw; bus.cpu_addr = ca;
        bus.cpu_wdata = cd; bus.per_req = pr; bus.per_addr = pa;
    endtask

    // Apply inputs at the falling edge, then settle before sampling.
    task automatic cycle(input bit r, input bit cr, input bit cw, input logic [9:0] ca,
                         input logic [31:0] cd, input bit pr, input logic [9:0] pa);
        @(negedge clk);
        set_inputs(r, cr, cw, ca, cd, pr, pa);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_inputs(1, 1, 1, 10'h3FF, 32'hFFFF_FFFF, 1, 10'h3FF);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", bus.enable); end
        checks++; if (bus.per_gnt !== 1'b0) begin errors++; $display("FAIL reset_per_gnt got=%b exp=0", bus.per_gnt); end
        checks++; if (bus.per_rvalid !== 1'b0) begin errors++; $display("FAIL reset_per_rvalid got=%b exp=0", bus.per_rvalid); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", bus.mem_wr); end
        checks++; if (bus.mem_addr !== 10'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
        checks++; if (bus.per_rdata !== 32'h0) begin errors++; $display("FAIL reset_per_rdata got=%h exp=0", bus.per_rdata); end
        @(negedge clk);
        reset = 1'b0;
        set_inputs(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_store();
        cycle(1, 1, 1, 10'h010, 32'hDEAD_BEEF, 0, 0);
        checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL store_mem_wr got=%b exp=1", bus.mem_wr); end
        checks++; if (bus.mem_addr !== 10'h010) begin errors++; $display("FAIL store_mem_addr got=%h exp=010", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem_wdata got=%h exp=deadbeef", bus.mem_wdata); end
        checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL store_enable got=%b exp=1", bus.enable); end
        cycle(1, 0, 0, 0, 0, 0, 0);
        checks++; if (mem[10'h010] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_memword got=%h exp=deadbeef", mem[10'h010]); end
        checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL idle_enable got=%b exp=1", bus.enable); end
    endtask

    task automatic test_load();
        bit exp_en [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 10'h010, 0, 0, 0);
            checks++; if (bus.enable !== exp_en[i]) begin errors++; $display("FAIL load_enable[%0d] got=%b exp=%b", i, bus.enable, exp_en[i]); end
            checks++; if (bus.per_gnt !== 1'b0) begin errors++; $display("FAIL load_per_gnt[%0d] got=%b exp=0", i, bus.per_gnt); end
            checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL load_mem_wr[%0d] got=%b exp=0", i, bus.mem_wr); end
        end
        checks++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_cpu_rdata got=%h exp=deadbeef", bus.cpu_rdata); end
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_conflict();
        bit cpu_wins;
        bit exp_rv;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 1, 10'h030, 32'h1111_0000 + i, 1, 10'h020);
            cpu_wins = (i % 2 == 0);
            exp_rv   = (i > 0) && (i % 2 == 0);
            checks++; if (bus.enable !== cpu_wins) begin errors++; $display("FAIL conflict_enable[%0d] got=%b exp=%b", i, bus.enable, cpu_wins); end
            checks++; if (bus.per_gnt !== !cpu_wins) begin errors++; $display("FAIL conflict_per_gnt[%0d] got=%b exp=%b", i, bus.per_gnt, !cpu_wins); end
            checks++; if (bus.mem_wr !== cpu_wins) begin errors++; $display("FAIL conflict_mem_wr[%0d] got=%b exp=%b", i, bus.mem_wr, cpu_wins); end
            checks++; if (bus.mem_addr !== (cpu_wins ? 10'h030 : 10'h020)) begin errors++; $display("FAIL conflict_mem_addr[%0d] got=%h", i, bus.mem_addr); end
            checks++; if (bus.per_rvalid !== exp_rv) begin errors++; $display("FAIL conflict_per_rvalid[%0d] got=%b exp=%b", i, bus.per_rvalid, exp_rv); end
            if (exp_rv) begin
                checks++; if (bus.per_rdata !== 32'h1234_5678) begin errors++; $display("FAIL conflict_per_rdata[%0d] got=%h exp=12345678", i, bus.per_rdata); end
            end
        end
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_per_during_load();
        cycle(1, 1, 0, 10'h010, 0, 0, 0);
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL pdl_enable0 got=%b exp=0", bus.enable); end
        cycle(1, 1, 0, 10'h010, 0, 1, 10'h020);
        checks++; if (bus.per_gnt !== 1'b1) begin errors++; $display("FAIL pdl_per_gnt_rd got=%b exp=1", bus.per_gnt); end
        checks++; if (bus.mem_addr !== 10'h020) begin errors++; $display("FAIL pdl_mem_addr got=%h exp=020", bus.mem_addr); end
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL pdl_enable1 got=%b exp=0", bus.enable); end
        cycle(1, 1, 0, 10'h010, 0, 1, 10'h020);
        checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL pdl_enable2 got=%b exp=1", bus.enable); end
        checks++; if (bus.per_rvalid !== 1'b1) begin errors++; $display("FAIL pdl_per_rvalid got=%b exp=1", bus.per_rvalid); end
        checks++; if (bus.per_rdata !== 32'h1234_5678) begin errors++; $display("FAIL pdl_per_rdata got=%h exp=12345678", bus.per_rdata); end
        checks++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pdl_cpu_rdata got=%h exp=deadbeef", bus.cpu_rdata); end
        cycle(1, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.per_rdata !== 32'h1234_5678) begin errors++; $display("FAIL pdl_per_rdata_hold got=%h exp=12345678", bus.per_rdata); end
    endtask

    task automatic test_run_hold();
        bit run_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bit exp_en  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cycle(run_seq[i], 1, 0, 10'h020, 0, 0, 0);
            checks++; if (bus.enable !== exp_en[i]) begin errors++; $display("FAIL runhold_enable[%0d] got=%b exp=%b", i, bus.enable, exp_en[i]); end
            if (i >= 2) begin
                checks++; if (bus.cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL runhold_cpu_rdata[%0d] got=%h exp=12345678", i, bus.cpu_rdata); end
            end
        end
        cycle(1, 1, 1, 10'h050, 32'hA5A5_A5A5, 0, 0);
        checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL runhold_idle_enable got=%b exp=1", bus.enable); end
        checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL runhold_idle_mem_wr got=%b exp=1", bus.mem_wr); end
    endtask

    task automatic test_reset_midload();
        cycle(1, 1, 0, 10'h010, 0, 0, 0);
        cycle(1, 1, 0, 10'h010, 0, 1, 10'h020);
        checks++; if (bus.per_gnt !== 1'b1) begin errors++; $display("FAIL rml_per_gnt_pre got=%b exp=1", bus.per_gnt); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL rml_enable got=%b exp=0", bus.enable); end
        checks++; if (bus.per_gnt !== 1'b0) begin errors++; $display("FAIL rml_per_gnt got=%b exp=0", bus.per_gnt); end
        checks++; if (bus.per_rvalid !== 1'b0) begin errors++; $display("FAIL rml_per_rvalid got=%b exp=0", bus.per_rvalid); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rml_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
        checks++; if (bus.mem_addr !== 10'h0) begin errors++; $display("FAIL rml_mem_addr got=%h exp=0", bus.mem_addr); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_inputs(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 10'h040, 32'hCAFE_F00D, 0, 0);
        checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL rml_store_enable got=%b exp=1", bus.enable); end
        checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL rml_store_mem_wr got=%b exp=1", bus.mem_wr); end
        cycle(1, 0, 0, 0, 0, 0, 0);
        checks++; if (mem[10'h040] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rml_memword got=%h exp=cafef00d", mem[10'h040]); end
    endtask

    // Transaction-level model: a load is a 3-cycle transaction (request,
    // data return, commit), a store commits on grant, the peripheral gets
    // the word read at its grant one cycle later, and conflicts alternate.
    task automatic test_random();
        logic [31:0] sh [0:1023];
        int          ld_phase;
        bit          cpu_turn, rv, r, cr, cw, pr, cpu_in, cg, pg, en, ex_wr;
        logic [9:0]  ca, pa, last_addr, ex_addr;
        logic [31:0] cd, rv_data, per_hold, cpu_data, ld_data, last_wdata, ex_wdata, ex_prd;
        int          stalls, conflicts;
        do_reset();
        for (int i = 0; i < 1024; i++) sh[i] = mem[i];
        ld_phase = 0; cpu_turn = 1'b1; rv = 1'b0;
        rv_data = '0; per_hold = '0; cpu_data = '0; ld_data = '0;
        last_addr = '0; last_wdata = '0; stalls = 0; conflicts = 0;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 4) != 0);
            cr = $urandom_range(0, 1);
            cw = $urandom_range(0, 1);
            pr = $urandom_range(0, 1);
            ca = 10'h100 + 10'($urandom_range(0, 15));
            pa = 10'h100 + 10'($urandom_range(0, 15));
            cd = $urandom;
            cycle(r, cr, cw, ca, cd, pr, pa);
            cg = 1'b0; pg = 1'b0; en = 1'b0;
            if (ld_phase == 0) begin
                cpu_in = cr && r;
                if (cpu_in && pr) begin
                    cg = cpu_turn; pg = !cpu_turn; conflicts++;
                end else begin
                    cg = cpu_in; pg = pr;
                end
                en = cg ? cw : (cpu_in ? 1'b0 : r);
            end else begin
                pg = pr;
                en = (ld_phase == 2) ? r : 1'b0;
            end
            if (r && !en) stalls++;
            ex_wr    = cg && cw;
            ex_addr  = cg ? ca : (pg ? pa : last_addr);
            ex_wdata = ex_wr ? cd : last_wdata;
            ex_prd   = rv ? rv_data : per_hold;
            checks++; if (bus.enable !== en) begin errors++; $display("FAIL rnd_enable[%0d] got=%b exp=%b", n, bus.enable, en); end
            checks++; if (bus.per_gnt !== pg) begin errors++; $display("FAIL rnd_per_gnt[%0d] got=%b exp=%b", n, bus.per_gnt, pg); end
            checks++; if (bus.mem_wr !== ex_wr) begin errors++; $display("FAIL rnd_mem_wr[%0d] got=%b exp=%b", n, bus.mem_wr, ex_wr); end
            checks++; if (bus.mem_addr !== ex_addr) begin errors++; $display("FAIL rnd_mem_addr[%0d] got=%h exp=%h", n, bus.mem_addr, ex_addr); end
            checks++; if (bus.mem_wdata !== ex_wdata) begin errors++; $display("FAIL rnd_mem_wdata[%0d] got=%h exp=%h", n, bus.mem_wdata, ex_wdata); end
            checks++; if (bus.per_rvalid !== rv) begin errors++; $display("FAIL rnd_per_rvalid[%0d] got=%b exp=%b", n, bus.per_rvalid, rv); end
            checks++; if (bus.per_rdata !== ex_prd) begin errors++; $display("FAIL rnd_per_rdata[%0d] got=%h exp=%h", n, bus.per_rdata, ex_prd); end
            checks++; if (bus.cpu_rdata !== cpu_data) begin errors++; $display("FAIL rnd_cpu_rdata[%0d] got=%h exp=%h", n, bus.cpu_rdata, cpu_data); end
            // Effects of the coming clock edge
            if (rv) per_hold = rv_data;
            rv = pg;
            if (pg) rv_data = sh[pa];
            if (ld_phase == 1) begin
                cpu_data = ld_data; ld_phase = 2;
            end else if (ld_phase == 2) begin
                if (r) ld_phase = 0;
            end else if (cg && !cw) begin
                ld_data = sh[ca]; ld_phase = 1;
            end
            if (ex_wr) sh[ca] = cd;
            if (cg) cpu_turn = 1'b0;
            else if (pg) cpu_turn = 1'b1;
            last_addr  = ex_addr;
            last_wdata = ex_wdata;
        end
`ifdef DMEM_STALL_COUNT_EN
        @(negedge clk);
        #2;
        checks++; if (stall_cnt !== 32'(stalls)) begin errors++; $display("FAIL rnd_stall_cnt got=%0d exp=%0d", stall_cnt, stalls); end
        checks++; if (conflict_cnt !== 16'(conflicts)) begin errors++; $display("FAIL rnd_conflict_cnt got=%0d exp=%0d", conflict_cnt, conflicts); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h020]  = 32'h1234_5678;
        bus.mem_rdata = '0;
        test_reset();
        test_store();
        test_load();
        test_conflict();
        test_per_during_load();
        test_run_hold();
        test_reset_midload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
